// File: rtl/spwm_carrier_sched.sv
// SPWM triangular carrier generator and per-period sequencer.
// Config is shadowed in RUN and committed only at the carrier valley.
module spwm_carrier_sched #(
  parameter int          WIDTH     = 12,
  parameter int          PRESC_W   = 16,
  parameter int unsigned DEF_PEAK  = 511,
  parameter int unsigned DEF_PRESC = 0
) (
  input  logic               clk_int,
  input  logic               rst,
  input  logic               enable,
  input  logic [WIDTH-1:0]   cfg_peak,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               ref_ack,
  output logic [WIDTH-1:0]   carrier,
  output logic               dir,
  output logic               peak_stb,
  output logic               valley_stb,
  output logic               ref_req,
  output logic               ref_late,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   TWO_W = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [PRESC_W-1:0] ONE_P = {{(PRESC_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nx;
  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] presc_active;
  logic [PRESC_W-1:0] presc_pend;
  logic [WIDTH-1:0]   peak_active;
  logic [WIDTH-1:0]   peak_pend;
  logic [WIDTH-1:0]   peak_clamp;
  logic               pend_valid;
  logic [WIDTH-1:0]   carrier_nx;
  logic               dir_nx;
  logic               tick;
  logic               cfg_fire;
  logic               peak_evt;
  logic               valley_evt;
  logic               up_step;
  logic               up_turn;
  logic               dn_step;
  logic               dn_turn;

  assign busy       = (state != IDLE);
  assign tick       = busy && (presc_cnt == presc_active);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign peak_clamp = (cfg_peak < TWO_W) ? TWO_W : cfg_peak;

  assign up_step = tick && !dir && (carrier < peak_active);
  assign up_turn = tick && !dir && (carrier >= peak_active);
  assign dn_step = tick && dir && (carrier != '0);
  assign dn_turn = tick && dir && (carrier == '0);

  always_comb begin
    carrier_nx = carrier;
    dir_nx     = dir;
    unique case (1'b1)
      up_step: carrier_nx = carrier + ONE_W;
      up_turn: begin
        dir_nx     = 1'b1;
        carrier_nx = carrier - ONE_W;
      end
      dn_step: carrier_nx = carrier - ONE_W;
      dn_turn: begin
        dir_nx     = 1'b0;
        carrier_nx = carrier + ONE_W;
      end
      default: ;
    endcase
  end

  assign peak_evt   = tick && !dir_nx && (carrier_nx == peak_active);
  assign valley_evt = tick && dir_nx && (carrier_nx == '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (enable) state_nx = RUN;
      RUN:      if (!enable) state_nx = STOPPING;
      STOPPING: begin
        if (enable)          state_nx = RUN;
        else if (valley_evt) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_int) begin
    if (rst) begin
      state        <= IDLE;
      presc_cnt    <= '0;
      presc_active <= PRESC_W'(DEF_PRESC);
      presc_pend   <= '0;
      peak_active  <= WIDTH'(DEF_PEAK);
      peak_pend    <= '0;
      pend_valid   <= 1'b0;
      cfg_ready    <= 1'b1;
      carrier      <= '0;
      dir          <= 1'b0;
      peak_stb     <= 1'b0;
      valley_stb   <= 1'b0;
      ref_req      <= 1'b0;
      ref_late     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        presc_cnt  <= '0;
        carrier    <= '0;
        dir        <= 1'b0;
        peak_stb   <= 1'b0;
        valley_stb <= 1'b0;
        ref_req    <= 1'b0;
        ref_late   <= 1'b0;
        cfg_ready  <= 1'b1;
        if (cfg_fire) begin
          peak_active  <= peak_clamp;
          presc_active <= cfg_presc;
        end
      end else begin
        presc_cnt  <= tick ? '0 : presc_cnt + ONE_P;
        carrier    <= carrier_nx;
        dir        <= (state_nx == IDLE) ? 1'b0 : dir_nx;
        peak_stb   <= peak_evt;
        valley_stb <= valley_evt;
        if (valley_evt) begin
          ref_req <= 1'b1;
          if (ref_req && !ref_ack) ref_late <= 1'b1;
          if (pend_valid) begin
            peak_active  <= peak_pend;
            presc_active <= presc_pend;
            pend_valid   <= 1'b0;
          end
        end else if (ref_ack) begin
          ref_req <= 1'b0;
        end
        // ready reopens one clock after the shadow has been consumed
        if (cfg_fire) begin
          peak_pend  <= peak_clamp;
          presc_pend <= cfg_presc;
          pend_valid <= 1'b1;
          cfg_ready  <= 1'b0;
        end else if (!cfg_ready && !pend_valid) begin
          cfg_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spwm_carrier_sched.sv
// Scoreboard bench for spwm_carrier_sched: directed stimulus with
// hand-computed per-cycle snapshots checked by a negedge monitor.
module tb_spwm_carrier_sched;

  logic        clk_int = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] cfg_peak;
  logic [15:0] cfg_presc;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        ref_ack;
  logic [11:0] carrier;
  logic        dir;
  logic        peak_stb;
  logic        valley_stb;
  logic        ref_req;
  logic        ref_late;
  logic        busy;

  typedef struct {
    int cyc;
    int car;
    bit d;
    bit pk;
    bit vl;
    bit rq;
    bit lt;
    bit bz;
    bit rdy;
  } exp_t;

  localparam int END_CYC = 7116;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  spwm_carrier_sched dut (
    .clk_int    (clk_int),
    .rst        (rst),
    .enable     (enable),
    .cfg_peak   (cfg_peak),
    .cfg_presc  (cfg_presc),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .ref_ack    (ref_ack),
    .carrier    (carrier),
    .dir        (dir),
    .peak_stb   (peak_stb),
    .valley_stb (valley_stb),
    .ref_req    (ref_req),
    .ref_late   (ref_late),
    .busy       (busy)
  );

  always #5 clk_int = ~clk_int;
  always @(posedge clk_int) cyc <= cyc + 1;

  task automatic push(input int c, input int car, input bit d,
                      input bit pk, input bit vl, input bit rq,
                      input bit lt, input bit bz, input bit rdy);
    exp_q.push_back('{c, car, d, pk, vl, rq, lt, bz, rdy});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_int);
  endtask

  // monitor: every strobe or scheduled probe pops one snapshot
  always @(negedge clk_int) begin
    exp_t e;
    if (peak_stb || valley_stb ||
        (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
      n_vec++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_miss++;
        $display("FAIL unexpected_strobe cyc=%0d got pk=%b vl=%b c=%0d",
                 cyc, peak_stb, valley_stb, carrier);
      end else begin
        e = exp_q.pop_front();
        if (int'(carrier) != e.car || dir != e.d ||
            peak_stb != e.pk || valley_stb != e.vl ||
            ref_req != e.rq || ref_late != e.lt ||
            busy != e.bz || cfg_ready != e.rdy) begin
          n_miss++;
          $display({"FAIL snap@%0d got c=%0d d=%b pk=%b vl=%b rq=%b",
                    " lt=%b bz=%b rdy=%b want c=%0d d=%b pk=%b vl=%b",
                    " rq=%b lt=%b bz=%b rdy=%b"},
                   cyc, carrier, dir, peak_stb, valley_stb, ref_req,
                   ref_late, busy, cfg_ready, e.car, e.d, e.pk, e.vl,
                   e.rq, e.lt, e.bz, e.rdy);
        end
      end
    end
    if (cyc == END_CYC) begin
      n_vec++;
      if (exp_q.size() != 0) begin
        n_miss++;
        $display("FAIL queue_drain got %0d left want 0 (next cyc %0d)",
                 exp_q.size(), exp_q[0].cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got cyc=%0d want %0d", cyc, END_CYC);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_peak  = '0;
    cfg_presc = '0;
    ref_ack   = 1'b0;

    //   cyc  car  d pk vl rq lt bz rdy
    push(2,    0,  0, 0, 0, 0, 0, 0, 1);
    push(5,    0,  0, 0, 0, 0, 0, 1, 1);
    push(6,    1,  0, 0, 0, 0, 0, 1, 1);
    push(516,  511,0, 1, 0, 0, 0, 1, 1);
    push(517,  510,1, 0, 0, 0, 0, 1, 1);
    push(1027, 0,  1, 0, 1, 1, 0, 1, 1);
    push(1328, 301,0, 0, 0, 1, 0, 1, 0);
    push(1538, 511,0, 1, 0, 1, 0, 1, 0);
    push(2049, 0,  1, 0, 1, 1, 1, 1, 0);
    push(2050, 0,  1, 0, 0, 1, 1, 1, 1);
    push(2052, 0,  1, 0, 0, 1, 1, 1, 1);
    push(2053, 1,  0, 0, 0, 1, 1, 1, 1);
    push(2449, 100,0, 1, 0, 1, 1, 1, 1);
    push(2450, 100,0, 0, 0, 1, 1, 1, 1);
    push(2848, 1,  1, 0, 0, 1, 1, 1, 1);
    push(2849, 0,  0, 0, 1, 1, 1, 0, 1);
    push(2850, 0,  0, 0, 0, 0, 0, 0, 1);

    wait_cyc(2);    rst = 1'b0;
    wait_cyc(4);    enable = 1'b1;
    wait_cyc(1327);
    cfg_peak  = 12'd100;
    cfg_presc = 16'd3;
    cfg_valid = 1'b1;
    wait_cyc(1328); cfg_valid = 1'b0;
    wait_cyc(2449); enable = 1'b0;

    wait_cyc(2890);
    push(3301, 100,0, 1, 0, 0, 0, 1, 1);
    push(3701, 0,  1, 0, 1, 1, 0, 1, 1);
    push(4101, 100,0, 1, 0, 1, 0, 1, 1);
    push(4501, 0,  1, 0, 1, 1, 0, 1, 1);
    push(4601, 25, 0, 0, 0, 0, 0, 1, 1);
    push(4702, 50, 0, 0, 0, 0, 0, 1, 1);
    push(4901, 100,0, 1, 0, 0, 0, 1, 1);
    push(5301, 0,  0, 0, 1, 1, 0, 0, 1);
    push(5302, 0,  0, 0, 0, 0, 0, 0, 1);
    push(5350, 0,  0, 0, 0, 0, 0, 0, 1);
    push(5401, 0,  0, 0, 0, 0, 0, 1, 1);
    push(5405, 1,  0, 0, 0, 0, 0, 1, 1);
    push(5801, 100,0, 1, 0, 0, 0, 1, 1);
    push(6053, 37, 1, 0, 0, 0, 0, 1, 1);
    push(6054, 0,  0, 0, 0, 0, 0, 0, 1);
    push(6572, 511,0, 1, 0, 0, 0, 1, 1);
    push(7083, 0,  0, 0, 1, 1, 0, 0, 1);
    push(7101, 0,  0, 0, 0, 0, 0, 0, 1);
    push(7112, 1,  0, 0, 0, 0, 0, 1, 1);
    push(7113, 2,  0, 1, 0, 0, 0, 1, 1);
    push(7114, 1,  1, 0, 0, 0, 0, 1, 1);
    push(7115, 0,  1, 0, 1, 1, 0, 1, 1);
    push(7116, 1,  0, 0, 0, 1, 0, 1, 1);

    wait_cyc(2900); enable = 1'b1;
    wait_cyc(4500); ref_ack = 1'b1;
    wait_cyc(4501); ref_ack = 1'b0;
    wait_cyc(4600); ref_ack = 1'b1;
    wait_cyc(4601); ref_ack = 1'b0;
    wait_cyc(4701); enable = 1'b0;
    wait_cyc(5400); enable = 1'b1;
    wait_cyc(6053);
    rst    = 1'b1;
    enable = 1'b0;
    wait_cyc(6054); rst = 1'b0;
    wait_cyc(6060); enable = 1'b1;
    wait_cyc(6572); enable = 1'b0;
    wait_cyc(7100);
    cfg_peak  = 12'd1;
    cfg_presc = 16'd0;
    cfg_valid = 1'b1;
    wait_cyc(7101); cfg_valid = 1'b0;
    wait_cyc(7110); enable = 1'b1;
    wait_cyc(END_CYC);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
